sonar_uc: RTL and testbench

- Control unit (FSM) that sequences the sonar datapath through a repeating cycle:
  - trigger one ultrasonic distance measurement;
  - stream the 8-character angle/distance frame over the serial transmitter, one character at a time;
  - step the servo one position;
  - wait the inter-measurement interval.
- Adds an echo watchdog with bounded retries, so a missing echo cannot hang the system.
- Sits beside the sonar datapath: its outputs drive the datapath control inputs, and the datapath "fim_*" flags drive its inputs.

---
 rtl/sonar_uc.sv | 178 +++++++++++++++++
 tb/tb_sonar_uc.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sonar_uc.sv
// sonar_uc: control unit for the sonar datapath. Each position cycle runs a
// measurement, streams the 8-character frame, steps the servo and waits the
// inter-measurement interval. An echo watchdog with bounded retries keeps a
// missing echo from stalling the sweep.
module sonar_uc #(
    parameter int TIMEOUT        = 2_500_000,
    parameter int N_TIMEOUT      = 22,
    parameter int MAX_TENTATIVAS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       fim_distancia,
    input  logic       fim_transmissao,
    input  logic       fim_contador_serial,
    input  logic       fim_contador_intervalo,
    output logic       zera,
    output logic       reset_updown,
    output logic       medir,
    output logic       transmitir,
    output logic       conta_serial,
    output logic       conta_updown,
    output logic       conta_intervalo,
    output logic       pronto,
    output logic       erro_medida,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL          = 4'd0,
        PREPARACAO       = 4'd1,
        MEDIDA           = 4'd2,
        ESPERA_MEDIDA    = 4'd3,
        FALHA            = 4'd4,
        TRANSMITE        = 4'd5,
        ESPERA_TX        = 4'd6,
        PROXIMO_CHAR     = 4'd7,
        MOVE_SERVO       = 4'd8,
        ESPERA_INTERVALO = 4'd9
    } estado_t;

    // Last watchdog value before the measurement is declared failed; the
    // watchdog holds here, so it can never wrap back to zero.
    localparam logic [N_TIMEOUT-1:0] WD_LAST  = N_TIMEOUT'(TIMEOUT - 1);
    localparam logic [N_TIMEOUT-1:0] WD_ONE   = N_TIMEOUT'(1);
    localparam logic [2:0]           MAX_TENT = 3'(MAX_TENTATIVAS);

    estado_t              state_r;
    estado_t              next_state_s;
    logic [N_TIMEOUT-1:0] watchdog_r;
    logic [2:0]           tentativas_r;
    logic [2:0]           tentativas_inc_s;
    logic                 erro_medida_r;
    logic                 timeout_s;
    logic                 esgotou_s;

    assign timeout_s        = (watchdog_r == WD_LAST);
    assign tentativas_inc_s = tentativas_r + 3'd1;
    assign esgotou_s        = (tentativas_inc_s >= MAX_TENT);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= INICIAL;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a simultaneous echo and timeout resolves to the echo.
    always_comb begin
        next_state_s = INICIAL;
        case (state_r)
            INICIAL: begin
                if (ligar) next_state_s = PREPARACAO;
                else       next_state_s = INICIAL;
            end
            PREPARACAO:    next_state_s = MEDIDA;
            MEDIDA:        next_state_s = ESPERA_MEDIDA;
            ESPERA_MEDIDA: begin
                if (fim_distancia)  next_state_s = TRANSMITE;
                else if (timeout_s) next_state_s = FALHA;
                else                next_state_s = ESPERA_MEDIDA;
            end
            FALHA: begin
                if (esgotou_s) next_state_s = MOVE_SERVO;
                else           next_state_s = MEDIDA;
            end
            TRANSMITE:     next_state_s = ESPERA_TX;
            ESPERA_TX: begin
                if (fim_transmissao) next_state_s = PROXIMO_CHAR;
                else                 next_state_s = ESPERA_TX;
            end
            PROXIMO_CHAR: begin
                if (fim_contador_serial) next_state_s = MOVE_SERVO;
                else                     next_state_s = TRANSMITE;
            end
            MOVE_SERVO:    next_state_s = ESPERA_INTERVALO;
            ESPERA_INTERVALO: begin
                if (fim_contador_intervalo && ligar)       next_state_s = MEDIDA;
                else if (fim_contador_intervalo)           next_state_s = INICIAL;
                else                                       next_state_s = ESPERA_INTERVALO;
            end
            default:       next_state_s = INICIAL;
        endcase
    end

    // Watchdog, retry counter and sticky measurement-error flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            watchdog_r    <= '0;
            tentativas_r  <= 3'd0;
            erro_medida_r <= 1'b0;
        end else begin
            case (state_r)
                PREPARACAO: begin
                    watchdog_r    <= '0;
                    tentativas_r  <= 3'd0;
                    erro_medida_r <= 1'b0;
                end
                MEDIDA: begin
                    watchdog_r <= '0;
                end
                ESPERA_MEDIDA: begin
                    if (!timeout_s) begin
                        watchdog_r <= watchdog_r + WD_ONE;
                    end
                    if (fim_distancia) begin
                        tentativas_r  <= 3'd0;
                        erro_medida_r <= 1'b0;
                    end
                end
                FALHA: begin
                    if (esgotou_s) begin
                        tentativas_r  <= 3'd0;
                        erro_medida_r <= 1'b1;
                    end else begin
                        tentativas_r  <= tentativas_inc_s;
                    end
                end
                default: begin
                    watchdog_r <= watchdog_r;
                end
            endcase
        end
    end

    // Moore output decode from the state register only.
    always_comb begin
        zera            = 1'b0;
        reset_updown    = 1'b0;
        medir           = 1'b0;
        transmitir      = 1'b0;
        conta_serial    = 1'b0;
        conta_updown    = 1'b0;
        conta_intervalo = 1'b0;
        pronto          = 1'b0;
        case (state_r)
            PREPARACAO: begin
                zera         = 1'b1;
                reset_updown = 1'b1;
            end
            MEDIDA:           medir           = 1'b1;
            TRANSMITE:        transmitir      = 1'b1;
            PROXIMO_CHAR:     conta_serial    = 1'b1;
            MOVE_SERVO: begin
                conta_updown = 1'b1;
                pronto       = 1'b1;
            end
            ESPERA_INTERVALO: conta_intervalo = 1'b1;
            default:          zera            = 1'b0;
        endcase
    end

    assign erro_medida = erro_medida_r;
    assign db_estado   = state_r;

endmodule

// File: tb/tb_sonar_uc.sv
// Bench for sonar_uc: a behavioural datapath answers the control pulses, a
// monitor records the visited-state trace and pulse counts, and each test
// pushes its expected trace into a scoreboard queue before driving ligar.
module tb_sonar_uc;

    localparam int TO   = 16;
    localparam int MAXT = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ligar = 1'b0;
    logic       fim_distancia = 1'b0;
    logic       fim_transmissao = 1'b0;
    logic       fim_contador_serial = 1'b0;
    logic       fim_contador_intervalo = 1'b0;
    logic       zera, reset_updown, medir, transmitir, conta_serial;
    logic       conta_updown, conta_intervalo, pronto, erro_medida;
    logic [3:0] db_estado;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // datapath responder configuration
    int dist_delay = 5;
    int fail_n = 0;

    // monitor results
    int n_medir = 0, n_tx = 0, n_cs = 0, n_cu = 0, n_pronto = 0, n_ci = 0;
    int         medir_t[$];
    logic [3:0] obs_q[$];
    logic [3:0] exp_q[$];
    logic [3:0] last_st = 4'd0;

    sonar_uc #(.TIMEOUT(TO), .N_TIMEOUT(5), .MAX_TENTATIVAS(MAXT)) dut (
        .clock(clock), .reset(reset), .ligar(ligar),
        .fim_distancia(fim_distancia), .fim_transmissao(fim_transmissao),
        .fim_contador_serial(fim_contador_serial),
        .fim_contador_intervalo(fim_contador_intervalo),
        .zera(zera), .reset_updown(reset_updown), .medir(medir),
        .transmitir(transmitir), .conta_serial(conta_serial),
        .conta_updown(conta_updown), .conta_intervalo(conta_intervalo),
        .pronto(pronto), .erro_medida(erro_medida), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural datapath: echo, serial transmitter, char counter, interval counter.
    initial begin : datapath_model
        int dist_cnt, tx_cnt, int_cnt, char_idx, attempt;
        dist_cnt = 0; tx_cnt = 0; int_cnt = 0; char_idx = 0; attempt = 0;
        forever begin
            @(negedge clock);
            fim_distancia = 1'b0;
            fim_transmissao = 1'b0;
            fim_contador_intervalo = 1'b0;
            if (!reset || zera) begin
                dist_cnt = 0; tx_cnt = 0; int_cnt = 0; char_idx = 0; attempt = 0;
                fim_contador_serial = 1'b0;
            end else begin
                if (dist_cnt > 0) begin
                    dist_cnt--;
                    if (dist_cnt == 0) fim_distancia = 1'b1;
                end
                if (tx_cnt > 0) begin
                    tx_cnt--;
                    if (tx_cnt == 0) fim_transmissao = 1'b1;
                end
                if (medir) begin
                    attempt++;
                    if (attempt > fail_n) dist_cnt = dist_delay;
                end
                if (transmitir) tx_cnt = 4;
                // counter output reflects the index before this cycle's increment
                fim_contador_serial = (char_idx == 7);
                if (conta_serial) char_idx = (char_idx + 1) % 8;
                if (conta_updown) attempt = 0;
                if (conta_intervalo) begin
                    int_cnt++;
                    if (int_cnt == 3) begin
                        int_cnt = 0;
                        fim_contador_intervalo = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: pulse counts, medir timestamps and de-duplicated state trace.
    initial begin : monitor
        forever begin
            @(negedge clock);
            if (medir) begin
                n_medir++;
                medir_t.push_back(cyc);
            end
            if (transmitir)      n_tx++;
            if (conta_serial)    n_cs++;
            if (conta_updown)    n_cu++;
            if (pronto)          n_pronto++;
            if (conta_intervalo) n_ci++;
            if (db_estado != last_st) begin
                obs_q.push_back(db_estado);
                last_st = db_estado;
            end
        end
    end

    initial begin : global_timeout
        #500000;
        $display("FAIL global_timeout: simulation did not complete, got cycle %0d, expected finish", cyc);
        $fatal(1);
    end

    task automatic wait_state(input logic [3:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (db_estado == s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic push_frame();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(4'd5);
            exp_q.push_back(4'd6);
            exp_q.push_back(4'd7);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ligar = 1'b0;
        repeat (3) @(negedge clock);
        n_chk++;
        if ({zera, reset_updown, medir, transmitir, conta_serial, conta_updown,
             conta_intervalo, pronto, erro_medida, db_estado} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_held: got outputs %b state %0d, expected all 0", {zera, reset_updown,
                     medir, transmitir, conta_serial, conta_updown, conta_intervalo, pronto, erro_medida}, db_estado);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_chk++;
            if ({zera, reset_updown, medir, transmitir, conta_serial, conta_updown,
                 conta_intervalo, pronto, erro_medida, db_estado} !== 13'd0) begin
                n_fail++;
                $display("FAIL reset_idle: got outputs %b state %0d, expected all 0", {zera, reset_updown,
                         medir, transmitir, conta_serial, conta_updown, conta_intervalo, pronto, erro_medida}, db_estado);
            end
        end
    endtask

    task automatic test_single_position();
        bit ok;
        int k, m0, t0, s0, u0, p0, c0;
        logic [3:0] e_st, o_st;
        @(negedge clock);
        obs_q.delete(); medir_t.delete(); exp_q.delete();
        dist_delay = 5; fail_n = 0;
        m0 = n_medir; t0 = n_tx; s0 = n_cs; u0 = n_cu; p0 = n_pronto; c0 = n_ci;
        exp_q.push_back(4'd1); exp_q.push_back(4'd2); exp_q.push_back(4'd3);
        push_frame();
        exp_q.push_back(4'd8); exp_q.push_back(4'd9); exp_q.push_back(4'd0);
        ligar = 1'b1;
        k = cyc;
        wait_state(4'd8, 400, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL single_reach_servo: got timeout, expected MOVE_SERVO"); end
        ligar = 1'b0;
        wait_state(4'd0, 100, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL single_return_idle: got timeout, expected INICIAL"); end
        @(negedge clock);
        n_chk++;
        if (medir_t.size() < 1 || medir_t[0] - k != 2) begin
            n_fail++;
            $display("FAIL single_latency: got %0d cycles, expected 2", medir_t.size() > 0 ? medir_t[0] - k : -1);
        end
        n_chk++;
        if (n_medir - m0 != 1) begin n_fail++; $display("FAIL single_medir: got %0d, expected 1", n_medir - m0); end
        n_chk++;
        if (n_tx - t0 != 8) begin n_fail++; $display("FAIL single_tx: got %0d, expected 8", n_tx - t0); end
        n_chk++;
        if (n_cs - s0 != 8) begin n_fail++; $display("FAIL single_cs: got %0d, expected 8", n_cs - s0); end
        n_chk++;
        if (n_cu - u0 != 1 || n_pronto - p0 != 1) begin
            n_fail++;
            $display("FAIL single_servo: got updown %0d pronto %0d, expected 1 1", n_cu - u0, n_pronto - p0);
        end
        n_chk++;
        if (n_ci - c0 < 1) begin n_fail++; $display("FAIL single_interval: got %0d, expected >=1", n_ci - c0); end
        n_chk++;
        if (erro_medida !== 1'b0) begin n_fail++; $display("FAIL single_erro: got %b, expected 0", erro_medida); end
        n_chk++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL single_trace_len: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e_st = exp_q.pop_front(); o_st = obs_q.pop_front(); n_chk++;
            if (o_st !== e_st) begin n_fail++; $display("FAIL single_trace: got state %0d, expected %0d", o_st, e_st); end
        end
    endtask

    task automatic test_timeout_retries();
        bit ok;
        int m0, t0, u0;
        logic [3:0] e_st, o_st;
        @(negedge clock);
        obs_q.delete(); medir_t.delete(); exp_q.delete();
        dist_delay = 5; fail_n = 99;
        m0 = n_medir; t0 = n_tx; u0 = n_cu;
        exp_q.push_back(4'd1);
        for (int i = 0; i < MAXT; i++) begin
            exp_q.push_back(4'd2); exp_q.push_back(4'd3); exp_q.push_back(4'd4);
        end
        exp_q.push_back(4'd8); exp_q.push_back(4'd9);
        exp_q.push_back(4'd2); exp_q.push_back(4'd3);
        push_frame();
        exp_q.push_back(4'd8); exp_q.push_back(4'd9); exp_q.push_back(4'd0);
        ligar = 1'b1;
        wait_state(4'd8, 400, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL timeout_reach_servo: got timeout, expected MOVE_SERVO"); end
        @(negedge clock);
        n_chk++;
        if (erro_medida !== 1'b1) begin n_fail++; $display("FAIL timeout_erro_set: got %b, expected 1", erro_medida); end
        n_chk++;
        if (n_medir - m0 != 3) begin n_fail++; $display("FAIL timeout_medir: got %0d, expected 3", n_medir - m0); end
        n_chk++;
        if (n_tx - t0 != 0) begin n_fail++; $display("FAIL timeout_tx: got %0d, expected 0", n_tx - t0); end
        n_chk++;
        if (n_cu - u0 != 1) begin n_fail++; $display("FAIL timeout_updown: got %0d, expected 1", n_cu - u0); end
        for (int i = 1; i < 3; i++) begin
            n_chk++;
            if (medir_t.size() < 3 || medir_t[i] - medir_t[i-1] != TO + 2) begin
                n_fail++;
                $display("FAIL timeout_spacing: got %0d, expected %0d", medir_t.size() > i ? medir_t[i] - medir_t[i-1] : -1, TO + 2);
            end
        end
        fail_n = 0;
        wait_state(4'd8, 400, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL timeout_second_pos: got timeout, expected MOVE_SERVO"); end
        ligar = 1'b0;
        wait_state(4'd0, 100, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL timeout_return_idle: got timeout, expected INICIAL"); end
        @(negedge clock);
        n_chk++;
        if (erro_medida !== 1'b0) begin n_fail++; $display("FAIL timeout_erro_clear: got %b, expected 0", erro_medida); end
        n_chk++;
        if (n_tx - t0 != 8) begin n_fail++; $display("FAIL timeout_tx2: got %0d, expected 8", n_tx - t0); end
        n_chk++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL timeout_trace_len: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e_st = exp_q.pop_front(); o_st = obs_q.pop_front(); n_chk++;
            if (o_st !== e_st) begin n_fail++; $display("FAIL timeout_trace: got state %0d, expected %0d", o_st, e_st); end
        end
    endtask

    task automatic test_third_attempt();
        bit ok;
        int m0, t0;
        logic [3:0] e_st, o_st;
        @(negedge clock);
        obs_q.delete(); medir_t.delete(); exp_q.delete();
        dist_delay = 5; fail_n = 2;
        m0 = n_medir; t0 = n_tx;
        exp_q.push_back(4'd1);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(4'd2); exp_q.push_back(4'd3); exp_q.push_back(4'd4);
        end
        exp_q.push_back(4'd2); exp_q.push_back(4'd3);
        push_frame();
        exp_q.push_back(4'd8); exp_q.push_back(4'd9); exp_q.push_back(4'd0);
        ligar = 1'b1;
        wait_state(4'd8, 400, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL third_reach_servo: got timeout, expected MOVE_SERVO"); end
        n_chk++;
        if (erro_medida !== 1'b0) begin n_fail++; $display("FAIL third_erro: got %b, expected 0", erro_medida); end
        ligar = 1'b0;
        wait_state(4'd0, 100, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL third_return_idle: got timeout, expected INICIAL"); end
        @(negedge clock);
        n_chk++;
        if (n_medir - m0 != 3) begin n_fail++; $display("FAIL third_medir: got %0d, expected 3", n_medir - m0); end
        n_chk++;
        if (n_tx - t0 != 8) begin n_fail++; $display("FAIL third_tx: got %0d, expected 8", n_tx - t0); end
        n_chk++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL third_trace_len: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e_st = exp_q.pop_front(); o_st = obs_q.pop_front(); n_chk++;
            if (o_st !== e_st) begin n_fail++; $display("FAIL third_trace: got state %0d, expected %0d", o_st, e_st); end
        end
    endtask

    task automatic test_watchdog_edge();
        bit ok;
        int m0;
        logic [3:0] e_st, o_st;
        @(negedge clock);
        obs_q.delete(); medir_t.delete(); exp_q.delete();
        dist_delay = TO; fail_n = 0;
        m0 = n_medir;
        exp_q.push_back(4'd1); exp_q.push_back(4'd2); exp_q.push_back(4'd3);
        push_frame();
        exp_q.push_back(4'd8); exp_q.push_back(4'd9); exp_q.push_back(4'd0);
        ligar = 1'b1;
        wait_state(4'd8, 400, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL edge_reach_servo: got timeout, expected MOVE_SERVO"); end
        ligar = 1'b0;
        wait_state(4'd0, 100, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL edge_return_idle: got timeout, expected INICIAL"); end
        @(negedge clock);
        n_chk++;
        if (n_medir - m0 != 1) begin n_fail++; $display("FAIL edge_medir: got %0d, expected 1", n_medir - m0); end
        n_chk++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL edge_trace_len: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e_st = exp_q.pop_front(); o_st = obs_q.pop_front(); n_chk++;
            if (o_st !== e_st) begin n_fail++; $display("FAIL edge_trace: got state %0d, expected %0d", o_st, e_st); end
        end
    endtask

    task automatic test_ligar_drop();
        bit ok;
        int t0, p0, seen;
        logic [3:0] e_st, o_st;
        @(negedge clock);
        obs_q.delete(); medir_t.delete(); exp_q.delete();
        dist_delay = 5; fail_n = 0;
        t0 = n_tx; p0 = n_pronto; seen = 0;
        exp_q.push_back(4'd1); exp_q.push_back(4'd2); exp_q.push_back(4'd3);
        push_frame();
        exp_q.push_back(4'd8); exp_q.push_back(4'd9); exp_q.push_back(4'd0);
        ligar = 1'b1;
        for (int i = 0; i < 200 && seen < 3; i++) begin
            @(negedge clock);
            if (transmitir) seen++;
        end
        n_chk++;
        if (seen != 3) begin n_fail++; $display("FAIL drop_char3: got %0d chars, expected 3", seen); end
        ligar = 1'b0;
        wait_state(4'd0, 400, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL drop_return_idle: got timeout, expected INICIAL"); end
        @(negedge clock);
        n_chk++;
        if (n_tx - t0 != 8) begin n_fail++; $display("FAIL drop_tx: got %0d, expected 8", n_tx - t0); end
        n_chk++;
        if (n_pronto - p0 != 1) begin n_fail++; $display("FAIL drop_pronto: got %0d, expected 1", n_pronto - p0); end
        n_chk++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL drop_trace_len: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e_st = exp_q.pop_front(); o_st = obs_q.pop_front(); n_chk++;
            if (o_st !== e_st) begin n_fail++; $display("FAIL drop_trace: got state %0d, expected %0d", o_st, e_st); end
        end
        ligar = 1'b1;
        wait_state(4'd1, 10, ok);
        n_chk++;
        if (!ok || zera !== 1'b1 || reset_updown !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_prep: got zera %b reset_updown %b, expected 1 1", zera, reset_updown);
        end
        @(negedge clock);
        n_chk++;
        if (zera !== 1'b0 || reset_updown !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_pulse_width: got zera %b reset_updown %b, expected 0 0", zera, reset_updown);
        end
        ligar = 1'b0;
        wait_state(4'd0, 400, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL restart_return_idle: got timeout, expected INICIAL"); end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        @(negedge clock);
        dist_delay = 5; fail_n = 0;
        ligar = 1'b1;
        wait_state(4'd6, 200, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL mid_reach_tx: got timeout, expected ESPERA_TX"); end
        reset = 1'b0;
        @(posedge clock);
        #1;
        n_chk++;
        if (db_estado !== 4'd0 || erro_medida !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_state: got state %0d erro %b, expected 0 0", db_estado, erro_medida);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_chk++;
            if (transmitir !== 1'b0 || conta_serial !== 1'b0 || db_estado !== 4'd0) begin
                n_fail++;
                $display("FAIL mid_reset_quiet: got tx %b cs %b state %0d, expected 0 0 0",
                         transmitir, conta_serial, db_estado);
            end
        end
        ligar = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        n_chk++;
        if (db_estado !== 4'd0) begin n_fail++; $display("FAIL mid_release: got state %0d, expected 0", db_estado); end
    endtask

    initial begin : main
        test_reset();
        test_single_position();
        test_timeout_retries();
        test_third_attempt();
        test_watchdog_edge();
        test_ligar_drop();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
